// File: rtl/ycc_pkg.sv
// Shared constants for the YCbCr -> RGB converter: default widths, fixed-point
// coefficients, chroma offset and the width of the signed intermediate sums.
package ycc_pkg;

    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_FRAC_BITS = 8;

    // round(c * 2^frac) with c given in millionths
    function automatic int unsigned coef(input int unsigned micro, input int unsigned frac);
        logic [63:0] scaled;
        scaled = (64'(micro) << frac) + 64'd500000;
        return 32'(scaled / 64'd1000000);
    endfunction

    // Chroma channels are offset by half the code range
    function automatic int unsigned chroma_offset(input int unsigned data_w);
        return 32'd1 << (data_w - 1);
    endfunction

    // Y<<frac plus the largest product needs data_w+frac+2 bits; keep some headroom
    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned frac_bits);
        return data_w + frac_bits + 4;
    endfunction

    localparam int unsigned KRCR          = coef(1402000, DEF_FRAC_BITS);  // 359
    localparam int unsigned KGCB          = coef(344136, DEF_FRAC_BITS);   // 88
    localparam int unsigned KGCR          = coef(714136, DEF_FRAC_BITS);   // 183
    localparam int unsigned KBCB          = coef(1772000, DEF_FRAC_BITS);  // 454
    localparam int unsigned CHROMA_OFFSET = chroma_offset(DEF_DATA_W);     // 128
    localparam int unsigned DEF_ACC_W     = acc_width(DEF_DATA_W, DEF_FRAC_BITS);  // 20

endpackage

// File: rtl/ycc_clamp_u8.sv
// Combinational fixed-point to unsigned-pixel conversion: floor shift of the
// rounded signed sum, then saturation to 0..2^DATA_W-1.
// CLIP_FLAG_EN adds the clip output (high when saturation changed the value).
module ycc_clamp_u8 import ycc_pkg::*; #(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned FRAC_BITS = DEF_FRAC_BITS,
    parameter int unsigned ACC_W     = DEF_ACC_W
) (
    input  logic signed [ACC_W-1:0] sum,
    output logic        [DATA_W-1:0] value
`ifdef CLIP_FLAG_EN
    ,
    output logic                     clip
`endif
);

    localparam logic signed [ACC_W-1:0] MAX_VAL = ACC_W'((1 << DATA_W) - 1);

    logic signed [ACC_W-1:0] shifted;
    logic                    under;
    logic                    over;

    assign shifted = sum >>> FRAC_BITS;
    assign under   = shifted < 0;
    assign over    = shifted > MAX_VAL;

    // Saturate to the unsigned pixel range
    always_comb begin
        value = shifted[DATA_W-1:0];
        if (under) begin
            value = '0;
        end else if (over) begin
            value = '1;
        end
    end

`ifdef CLIP_FLAG_EN
    assign clip = under | over;
`endif

endmodule

// File: rtl/ycbcr_to_rgb.sv
// Three-stage full-range BT.601 YCbCr -> RGB converter with valid/ready on both
// sides. The whole pipeline advances together and stalls while the output
// holds an unaccepted result.
// CLIP_FLAG_EN adds the clip_flag output (any channel saturated for the pixel).
module ycbcr_to_rgb import ycc_pkg::*; #(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] luma_ch,
    input  logic [DATA_W-1:0] cb_ch,
    input  logic [DATA_W-1:0] cr_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] red_ch,
    output logic [DATA_W-1:0] green_ch,
    output logic [DATA_W-1:0] blue_ch
`ifdef CLIP_FLAG_EN
    ,
    output logic              clip_flag
`endif
);

    localparam int unsigned ACC_W = acc_width(DATA_W, FRAC_BITS);

    localparam logic signed [ACC_W-1:0] K_RCR = ACC_W'(coef(1402000, FRAC_BITS));
    localparam logic signed [ACC_W-1:0] K_GCB = ACC_W'(coef(344136, FRAC_BITS));
    localparam logic signed [ACC_W-1:0] K_GCR = ACC_W'(coef(714136, FRAC_BITS));
    localparam logic signed [ACC_W-1:0] K_BCB = ACC_W'(coef(1772000, FRAC_BITS));
    localparam logic signed [ACC_W-1:0] ROUND = ACC_W'(1 << (FRAC_BITS - 1));
    localparam logic        [DATA_W:0]  OFFSET = (DATA_W + 1)'(chroma_offset(DATA_W));

    logic                    en;
    logic                    v1, v2;
    logic [DATA_W-1:0]       y1, y2;
    logic signed [DATA_W:0]  dcb_in, dcr_in;
    logic signed [DATA_W:0]  dcb1, dcr1;
    logic signed [ACC_W-1:0] dcb_ext, dcr_ext, y_ext;
    logic signed [ACC_W-1:0] pr2, pg2, pb2;
    logic signed [ACC_W-1:0] sum_r, sum_g, sum_b;
    logic [DATA_W-1:0]       r_c, g_c, b_c;

    // A full output register that is not being taken freezes every stage
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    assign dcb_in  = $signed({1'b0, cb_ch} - OFFSET);
    assign dcr_in  = $signed({1'b0, cr_ch} - OFFSET);
    assign dcb_ext = {{(ACC_W - DATA_W - 1){dcb1[DATA_W]}}, dcb1};
    assign dcr_ext = {{(ACC_W - DATA_W - 1){dcr1[DATA_W]}}, dcr1};
    assign y_ext   = $signed({{(ACC_W - DATA_W){1'b0}}, y2});

    assign sum_r = (y_ext << FRAC_BITS) + pr2 + ROUND;
    assign sum_g = (y_ext << FRAC_BITS) + pg2 + ROUND;
    assign sum_b = (y_ext << FRAC_BITS) + pb2 + ROUND;

    // Stage 1: capture luma and centred chroma
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1   <= 1'b0;
            y1   <= '0;
            dcb1 <= '0;
            dcr1 <= '0;
        end else if (en) begin
            v1   <= in_valid;
            y1   <= luma_ch;
            dcb1 <= dcb_in;
            dcr1 <= dcr_in;
        end
    end

    // Stage 2: signed chroma products
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2  <= 1'b0;
            y2  <= '0;
            pr2 <= '0;
            pg2 <= '0;
            pb2 <= '0;
        end else if (en) begin
            v2  <= v1;
            y2  <= y1;
            pr2 <= K_RCR * dcr_ext;
            pg2 <= -((K_GCB * dcb_ext) + (K_GCR * dcr_ext));
            pb2 <= K_BCB * dcb_ext;
        end
    end

`ifdef CLIP_FLAG_EN
    logic clip_r, clip_g, clip_b;
`endif

    ycc_clamp_u8 #(
        .DATA_W    (DATA_W),
        .FRAC_BITS (FRAC_BITS),
        .ACC_W     (ACC_W)
    ) u_clamp_r (
        .sum   (sum_r),
        .value (r_c)
`ifdef CLIP_FLAG_EN
        ,
        .clip  (clip_r)
`endif
    );

    ycc_clamp_u8 #(
        .DATA_W    (DATA_W),
        .FRAC_BITS (FRAC_BITS),
        .ACC_W     (ACC_W)
    ) u_clamp_g (
        .sum   (sum_g),
        .value (g_c)
`ifdef CLIP_FLAG_EN
        ,
        .clip  (clip_g)
`endif
    );

    ycc_clamp_u8 #(
        .DATA_W    (DATA_W),
        .FRAC_BITS (FRAC_BITS),
        .ACC_W     (ACC_W)
    ) u_clamp_b (
        .sum   (sum_b),
        .value (b_c)
`ifdef CLIP_FLAG_EN
        ,
        .clip  (clip_b)
`endif
    );

    // Stage 3: clamped RGB output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            red_ch    <= '0;
            green_ch  <= '0;
            blue_ch   <= '0;
        end else if (en) begin
            out_valid <= v2;
            red_ch    <= r_c;
            green_ch  <= g_c;
            blue_ch   <= b_c;
        end
    end

`ifdef CLIP_FLAG_EN
    // Clip indication travels with the RGB register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clip_flag <= 1'b0;
        end else if (en) begin
            clip_flag <= clip_r | clip_g | clip_b;
        end
    end
`endif

endmodule

// File: tb/tb_ycbcr_to_rgb.sv
// Directed bench for ycbcr_to_rgb: reset state, hand-computed conversions,
// latency, backpressure, throughput and mid-stream reset.
// Checks clip_flag too when CLIP_FLAG_EN is defined.
module tb_ycbcr_to_rgb;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] luma_ch, cb_ch, cr_ch;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] red_ch, green_ch, blue_ch;
    logic [23:0] rgb;
`ifdef CLIP_FLAG_EN
    logic       clip_flag;
`endif

    int checks = 0;
    int errors = 0;

    assign rgb = {red_ch, green_ch, blue_ch};

    always #5 clk = ~clk;

    ycbcr_to_rgb dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .luma_ch   (luma_ch),
        .cb_ch     (cb_ch),
        .cr_ch     (cr_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .red_ch    (red_ch),
        .green_ch  (green_ch),
        .blue_ch   (blue_ch)
`ifdef CLIP_FLAG_EN
        ,
        .clip_flag (clip_flag)
`endif
    );

    // Six hand-computed vectors reused by the backpressure stream
    logic [7:0]  vy   [6] = '{8'd128, 8'd100, 8'd0,   8'd0,   8'd255, 8'd16};
    logic [7:0]  vcb  [6] = '{8'd128, 8'd128, 8'd128, 8'd255, 8'd128, 8'd128};
    logic [7:0]  vcr  [6] = '{8'd128, 8'd200, 8'd255, 8'd128, 8'd128, 8'd128};
    logic [23:0] vrgb [6] = '{24'h808080, 24'hc93164, 24'hb20000, 24'h0000e1,
                              24'hffffff, 24'h101010};
    logic        vclip[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        pat  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One pixel through an idle pipeline with out_ready=1
    task automatic send_one(input string tag, input logic [7:0] y, input logic [7:0] cb,
                            input logic [7:0] cr, input logic [23:0] exp_rgb,
                            input logic exp_clip);
        in_valid = 1'b1;
        luma_ch  = y;
        cb_ch    = cb;
        cr_ch    = cr;
        #1;
        chk({tag, "_in_ready"}, 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        luma_ch  = 8'hA5;
        cb_ch    = 8'h5A;
        cr_ch    = 8'h3C;
        chk({tag, "_lat1"}, 32'(out_valid), 0);
        tick();
        chk({tag, "_lat2"}, 32'(out_valid), 0);
        tick();
        chk({tag, "_valid"}, 32'(out_valid), 1);
        chk({tag, "_rgb"}, 32'(rgb), 32'(exp_rgb));
`ifdef CLIP_FLAG_EN
        chk({tag, "_clip"}, 32'(clip_flag), 32'(exp_clip));
`else
        if (exp_clip === 1'bx) $display("unexpected clip argument");
`endif
        tick();
        chk({tag, "_drain"}, 32'(out_valid), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int got;
        logic hold;
        logic in_fire;
        logic [23:0] held_rgb;
        logic [7:0]  ey;
        logic        exp_v;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        luma_ch   = 8'h00;
        cb_ch     = 8'h00;
        cr_ch     = 8'h00;
        repeat (3) tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_rgb", 32'(rgb), 0);
`ifdef CLIP_FLAG_EN
        chk("rst_clip", 32'(clip_flag), 0);
`endif
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 1);
        chk("post_rst_out_valid", 32'(out_valid), 0);

        // Garbage with in_valid=0 must not create results
        luma_ch = 8'h77;
        cb_ch   = 8'h11;
        cr_ch   = 8'hEE;
        repeat (4) tick();
        chk("idle_no_valid", 32'(out_valid), 0);

        send_one("grey", 8'd128, 8'd128, 8'd128, 24'h808080, 1'b0);
        send_one("chroma", 8'd100, 8'd128, 8'd200, 24'hc93164, 1'b0);
        send_one("red_sat", 8'd0, 8'd128, 8'd255, 24'hb20000, 1'b1);
        send_one("blue_sat", 8'd0, 8'd255, 8'd128, 24'h0000e1, 1'b1);
        send_one("white", 8'd255, 8'd128, 8'd128, 24'hffffff, 1'b0);

        // Backpressure: out_ready follows 1,0,0,1,0,1 repeating
        sent = 0;
        got  = 0;
        for (int c = 0; c < 80 && got < 6; c++) begin
            out_ready = pat[c % 6];
            if (sent < 6) begin
                in_valid = 1'b1;
                luma_ch  = vy[sent];
                cb_ch    = vcb[sent];
                cr_ch    = vcr[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) chk("bp_stall_in_ready", 32'(in_ready), 0);
            in_fire = in_valid && in_ready;
            if (out_valid && out_ready) begin
                chk("bp_data", 32'(rgb), 32'(vrgb[got]));
`ifdef CLIP_FLAG_EN
                chk("bp_clip", 32'(clip_flag), 32'(vclip[got]));
`endif
                got++;
            end
            hold     = out_valid && !out_ready;
            held_rgb = rgb;
            tick();
            if (hold) begin
                chk("bp_hold_valid", 32'(out_valid), 1);
                chk("bp_hold_rgb", 32'(rgb), 32'(held_rgb));
            end
            if (in_fire) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_count", 32'(got), 6);
        chk("bp_no_dup", 32'(out_valid), 0);
        repeat (4) tick();

        // Throughput: 16 back-to-back grey pixels, Y = 16k+3
        for (int n = 0; n < 20; n++) begin
            if (n < 16) begin
                in_valid = 1'b1;
                luma_ch  = 8'(n * 16 + 3);
                cb_ch    = 8'd128;
                cr_ch    = 8'd128;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            exp_v = (n >= 2) && (n < 18);
            chk("tp_valid", 32'(out_valid), 32'(exp_v));
            if (exp_v) begin
                ey = 8'((n - 2) * 16 + 3);
                chk("tp_data", 32'(rgb), 32'({ey, ey, ey}));
            end
        end
        repeat (2) tick();

        // Reset with three pixels in flight
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            luma_ch  = vy[k + 1];
            cb_ch    = vcb[k + 1];
            cr_ch    = vcr[k + 1];
            tick();
        end
        in_valid = 1'b0;
        chk("mid_full_valid", 32'(out_valid), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_rgb", 32'(rgb), 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("mid_no_ghost", 32'(out_valid), 0);
        send_one("after_rst", 8'd100, 8'd128, 8'd200, 24'hc93164, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
